// File: rtl/io_input_capture.sv
// Switch and push-button input capture: 2-flop synchronizers, shared-counter debounce,
// press pulse/counter and a sticky press-pending event handshake with overrun flag.
module io_input_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sw_in,
  input  logic        btn_in,
  input  logic        evt_ack,
  output logic [15:0] sw_value,
  output logic        sw_changed,
  output logic        btn_level,
  output logic        btn_pulse,
  output logic        evt_valid,
  output logic        evt_overrun,
  output logic [15:0] press_count
);

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    EVT_IDLE    = 1'b0,
    EVT_PENDING = 1'b1
  } evt_state_e;

  logic [15:0] sw_s1_q, sw_s2_q, sw_cand_q, sw_cand_d, sw_value_q, sw_value_d;
  logic [19:0] sw_cnt_q, sw_cnt_d;
  logic        sw_changed_q, sw_changed_d;
  logic        btn_s1_q, btn_s2_q, btn_cand_q, btn_cand_d, btn_level_q, btn_level_d;
  logic [19:0] btn_cnt_q, btn_cnt_d;
  logic        btn_pulse_q, btn_pulse_d;
  logic [15:0] press_count_q, press_count_d;
  evt_state_e  evt_state_q, evt_state_d;
  logic        evt_overrun_q, evt_overrun_d;

  // Switch debounce: any bit differing from the candidate restarts the shared count.
  always_comb begin
    sw_cand_d    = sw_cand_q;
    sw_cnt_d     = sw_cnt_q;
    sw_value_d   = sw_value_q;
    sw_changed_d = 1'b0;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      sw_cnt_d  = 20'd0;
    end else if (sw_cnt_q < CNT_LAST) begin
      sw_cnt_d = sw_cnt_q + 20'd1;
    end else begin
      sw_value_d   = sw_cand_q;
      sw_changed_d = (sw_cand_q != sw_value_q);
    end
  end

  // Button debounce with its own candidate and counter; pulse only on a 0->1 commit.
  always_comb begin
    btn_cand_d  = btn_cand_q;
    btn_cnt_d   = btn_cnt_q;
    btn_level_d = btn_level_q;
    btn_pulse_d = 1'b0;
    if (btn_s2_q != btn_cand_q) begin
      btn_cand_d = btn_s2_q;
      btn_cnt_d  = 20'd0;
    end else if (btn_cnt_q < CNT_LAST) begin
      btn_cnt_d = btn_cnt_q + 20'd1;
    end else begin
      btn_level_d = btn_cand_q;
      btn_pulse_d = btn_cand_q & ~btn_level_q;
    end
  end

  // Event handshake; a press coinciding with an ack replaces the consumed event cleanly.
  always_comb begin
    evt_state_d   = evt_state_q;
    evt_overrun_d = evt_overrun_q;
    if (btn_pulse_q) begin
      press_count_d = press_count_q + 16'd1;
    end else begin
      press_count_d = press_count_q;
    end
    case (evt_state_q)
      EVT_IDLE: begin
        if (btn_pulse_q) begin
          evt_state_d = EVT_PENDING;
        end else begin
          evt_state_d = EVT_IDLE;
        end
      end
      EVT_PENDING: begin
        if (btn_pulse_q) begin
          evt_overrun_d = ~evt_ack;
        end else if (evt_ack) begin
          evt_state_d   = EVT_IDLE;
          evt_overrun_d = 1'b0;
        end else begin
          evt_state_d = EVT_PENDING;
        end
      end
      default: begin
        evt_state_d   = EVT_IDLE;
        evt_overrun_d = 1'b0;
      end
    endcase
  end

  // State registers, including the synchronizers which are the only raw-input samplers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1_q       <= 16'h0000;
      sw_s2_q       <= 16'h0000;
      sw_cand_q     <= 16'h0000;
      sw_cnt_q      <= 20'd0;
      sw_value_q    <= 16'h0000;
      sw_changed_q  <= 1'b0;
      btn_s1_q      <= 1'b0;
      btn_s2_q      <= 1'b0;
      btn_cand_q    <= 1'b0;
      btn_cnt_q     <= 20'd0;
      btn_level_q   <= 1'b0;
      btn_pulse_q   <= 1'b0;
      press_count_q <= 16'h0000;
      evt_state_q   <= EVT_IDLE;
      evt_overrun_q <= 1'b0;
    end else begin
      sw_s1_q       <= sw_in;
      sw_s2_q       <= sw_s1_q;
      sw_cand_q     <= sw_cand_d;
      sw_cnt_q      <= sw_cnt_d;
      sw_value_q    <= sw_value_d;
      sw_changed_q  <= sw_changed_d;
      btn_s1_q      <= btn_in;
      btn_s2_q      <= btn_s1_q;
      btn_cand_q    <= btn_cand_d;
      btn_cnt_q     <= btn_cnt_d;
      btn_level_q   <= btn_level_d;
      btn_pulse_q   <= btn_pulse_d;
      press_count_q <= press_count_d;
      evt_state_q   <= evt_state_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  assign sw_value    = sw_value_q;
  assign sw_changed  = sw_changed_q;
  assign btn_level   = btn_level_q;
  assign btn_pulse   = btn_pulse_q;
  assign evt_valid   = (evt_state_q == EVT_PENDING);
  assign evt_overrun = evt_overrun_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_io_input_capture.sv
// Bench for io_input_capture (DEBOUNCE_CYCLES=4): directed scenarios plus random bouncing
// inputs checked against a sliding-window reference model.
module tb_io_input_capture;
  localparam int D = 4;

  logic        clock;
  logic        reset;
  logic [15:0] sw_in;
  logic        btn_in;
  logic        evt_ack;
  logic [15:0] sw_value;
  logic        sw_changed;
  logic        btn_level;
  logic        btn_pulse;
  logic        evt_valid;
  logic        evt_overrun;
  logic [15:0] press_count;

  int errors = 0;
  int checks = 0;

  io_input_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .sw_in(sw_in), .btn_in(btn_in), .evt_ack(evt_ack),
    .sw_value(sw_value), .sw_changed(sw_changed), .btn_level(btn_level),
    .btn_pulse(btn_pulse), .evt_valid(evt_valid), .evt_overrun(evt_overrun),
    .press_count(press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a value is accepted once the last D+1 synchronized samples agree;
  // a synchronized sample is simply the pin value two edges earlier.
  logic [15:0] hs[$];
  logic        hb[$];
  logic [15:0] exp_sw, exp_count;
  logic        exp_sw_ch, exp_btn, exp_pulse, exp_valid, exp_over;
  logic        m_ok, m_sw_ch, m_pulse;

  always @(posedge clock) begin
    if (reset) begin
      hs.delete(); hb.delete();
      exp_sw = 16'h0000; exp_sw_ch = 1'b0; exp_btn = 1'b0; exp_pulse = 1'b0;
      exp_valid = 1'b0; exp_over = 1'b0; exp_count = 16'h0000;
    end else begin
      if (exp_pulse) begin
        exp_count = exp_count + 16'd1;
        if (exp_valid && !evt_ack) exp_over = 1'b1;
        else if (exp_valid) exp_over = 1'b0;
        exp_valid = 1'b1;
      end else if (evt_ack && exp_valid) begin
        exp_valid = 1'b0;
        exp_over  = 1'b0;
      end
      hs.push_back(sw_in);
      hb.push_back(btn_in);
      if (hs.size() > D + 3) begin
        void'(hs.pop_front());
        void'(hb.pop_front());
      end
      m_sw_ch = 1'b0;
      m_pulse = 1'b0;
      if (hs.size() == D + 3) begin
        m_ok = 1'b1;
        for (int k = 1; k <= D; k++) if (hs[k] != hs[0]) m_ok = 1'b0;
        if (m_ok) begin
          m_sw_ch = (hs[0] != exp_sw);
          exp_sw  = hs[0];
        end
        m_ok = 1'b1;
        for (int k = 1; k <= D; k++) if (hb[k] != hb[0]) m_ok = 1'b0;
        if (m_ok) begin
          m_pulse = hb[0] && !exp_btn;
          exp_btn = hb[0];
        end
      end
      exp_sw_ch = m_sw_ch;
      exp_pulse = m_pulse;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sw_in = 16'h0000; btn_in = 1'b0; evt_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic press(input logic ack_on_pulse);
    logic found = 1'b0;
    btn_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!found && btn_pulse === 1'b1) begin
        found = 1'b1;
        if (ack_on_pulse) begin
          evt_ack = 1'b1;
          tick();
          evt_ack = 1'b0;
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL press_timeout: got no btn_pulse within 12 cycles, required one");
    end
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset();
    logic [36:0] act;
    reset = 1'b1; sw_in = 16'($urandom) | 16'h0001; btn_in = 1'b1; evt_ack = 1'b1;
    tick(); tick(); tick();
    act = {sw_value, sw_changed, btn_level, btn_pulse, evt_valid, evt_overrun, press_count};
    checks++;
    if (act !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", act, 37'd0);
    end
    reset = 1'b0; sw_in = 16'h0000; btn_in = 1'b0; evt_ack = 1'b0;
    tick();
  endtask

  task automatic test_sw_capture();
    do_reset();
    sw_in = 16'hA5C3;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (sw_value !== ((e >= 7) ? 16'hA5C3 : 16'h0000)) begin
        errors++;
        $display("FAIL sw_value_edge%0d: got %h required %h", e, sw_value,
                 (e >= 7) ? 16'hA5C3 : 16'h0000);
      end
      checks++;
      if (sw_changed !== (e == 7)) begin
        errors++;
        $display("FAIL sw_changed_edge%0d: got %b required %b", e, sw_changed, (e == 7));
      end
    end
    // short glitch must be filtered and produce no change pulse
    sw_in = 16'hA5C2;
    for (int i = 0; i < 3; i++) tick();
    sw_in = 16'hA5C3;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (sw_value !== 16'hA5C3 || sw_changed !== 1'b0) begin
        errors++;
        $display("FAIL sw_glitch: got %h/%b required a5c3/0", sw_value, sw_changed);
      end
    end
  endtask

  task automatic test_btn_bounce();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      btn_in = (i < 3) || (i >= 5 && i < 15);
      tick();
      if (btn_pulse === 1'b1) pulses++;
    end
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (btn_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL bounce_pulses: got %0d required 1", pulses); end
    checks++;
    if (press_count !== 16'd1) begin errors++; $display("FAIL bounce_count: got %h required 0001", press_count); end
    checks++;
    if (evt_valid !== 1'b1 || evt_overrun !== 1'b0) begin
      errors++; $display("FAIL bounce_evt: got valid=%b ovr=%b required 1/0", evt_valid, evt_overrun);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    press(1'b0);
    press(1'b0);
    checks++;
    if ({press_count, evt_valid, evt_overrun} !== {16'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overrun_set: got cnt=%h v=%b o=%b required 0002/1/1", press_count, evt_valid, evt_overrun);
    end
    evt_ack = 1'b1; tick(); evt_ack = 1'b0; tick();
    checks++;
    if (evt_valid !== 1'b0 || evt_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_ack: got v=%b o=%b required 0/0", evt_valid, evt_overrun);
    end
    evt_ack = 1'b1; tick(); evt_ack = 1'b0; tick();
    checks++;
    if (evt_valid !== 1'b0 || evt_overrun !== 1'b0) begin
      errors++; $display("FAIL idle_ack: got v=%b o=%b required 0/0", evt_valid, evt_overrun);
    end
  endtask

  task automatic test_ack_same_cycle();
    do_reset();
    press(1'b0);
    press(1'b1);
    checks++;
    if ({press_count, evt_valid, evt_overrun} !== {16'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ack_with_pulse: got cnt=%h v=%b o=%b required 0002/1/0", press_count, evt_valid, evt_overrun);
    end
    press(1'b0);
    press(1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_overrun !== 1'b0) begin
      errors++; $display("FAIL ack_clears_overrun: got v=%b o=%b required 1/0", evt_valid, evt_overrun);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.press_count_q = 16'hFFFE;
    exp_count = 16'hFFFE;
    tick();
    release dut.press_count_q;
    tick();
    checks++;
    if (press_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h required fffe", press_count); end
    press(1'b0);
    checks++;
    if (press_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h required ffff", press_count); end
    press(1'b0);
    checks++;
    if (press_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h required 0000", press_count); end
  endtask

  task automatic test_reset_mid();
    logic [36:0] act;
    do_reset();
    sw_in = 16'h0001; btn_in = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    act = {sw_value, sw_changed, btn_level, btn_pulse, evt_valid, evt_overrun, press_count};
    checks++;
    if (act !== 37'd0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", act); end
    reset = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if ({sw_value, sw_changed, btn_level, btn_pulse} !==
          {((e >= 7) ? 16'h0001 : 16'h0000), (e == 7), (e >= 7), (e == 7)}) begin
        errors++;
        $display("FAIL midreset_edge%0d: got sw=%h ch=%b lvl=%b pul=%b required sw=%h ch=%b lvl=%b pul=%b",
                 e, sw_value, sw_changed, btn_level, btn_pulse,
                 (e >= 7) ? 16'h0001 : 16'h0000, (e == 7), (e >= 7), (e == 7));
      end
    end
    sw_in = 16'h0000; btn_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_random();
    logic [15:0] sw_tgt = 16'h0000;
    logic        btn_tgt = 1'b0;
    logic [36:0] act, exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15, 0) == 0) sw_tgt = 16'($urandom);
      if ($urandom_range(11, 0) == 0) btn_tgt = ~btn_tgt;
      sw_in = sw_tgt;
      if ($urandom_range(9, 0) == 0) sw_in = sw_tgt ^ (16'h0001 << $urandom_range(15, 0));
      btn_in  = btn_tgt ^ ($urandom_range(9, 0) == 0);
      evt_ack = ($urandom_range(3, 0) == 0);
      reset   = ($urandom_range(499, 0) == 0);
      tick();
      act = {sw_value, sw_changed, btn_level, btn_pulse, evt_valid, evt_overrun, press_count};
      exp = {exp_sw, exp_sw_ch, exp_btn, exp_pulse, exp_valid, exp_over, exp_count};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h required %h", i, act, exp);
      end
    end
    reset = 1'b0; evt_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sw_in = 16'h0000; btn_in = 1'b0; evt_ack = 1'b0;
    test_reset();
    test_sw_capture();
    test_btn_bounce();
    test_overrun();
    test_ack_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_input_capture.md
IO_INPUT_CAPTURE -- requirements
Module: io_input_capture

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clocks required before a synchronized input is accepted (10 ms at 100 MHz); legal range 2..2^20-1.
- REQ-002: clock  input  1  system clock; all state updates on the rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: sw_in  input  16  raw asynchronous slide-switch levels.
- REQ-005: btn_in  input  1  raw asynchronous push-button level (1 = pressed).
- REQ-006: evt_ack  input  1  processor acknowledge of a pending button event, one-cycle strobe.
- REQ-007: sw_value  output  16  debounced switch word, register-readable.
- REQ-008: sw_changed  output  1  one-cycle pulse when sw_value takes a new, different value.
- REQ-009: btn_level  output  1  debounced button level.
- REQ-010: btn_pulse  output  1  one-cycle pulse on debounced 0->1 transition.
- REQ-011: evt_valid  output  1  sticky "press pending" flag, held until acknowledged.
- REQ-012: evt_overrun  output  1  sticky flag: press arrived while evt_valid already set.
- REQ-013: press_count  output  16  count of debounced presses since reset.

Function
- REQ-014: Each input bit SHALL pass through a 2-flop synchronizer (s1<=in, s2<=s1); no other logic samples raw inputs.
- REQ-015: Switch debounce: one candidate register cand[15:0] and one counter cnt shared by all 16 bits.
- REQ-016: Per edge: if s2 != cand -> cand<=s2, cnt<=0; else if cnt < DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; else cnt holds and sw_value<=cand.
- REQ-017: A switch change stable at the pin SHALL appear on sw_value exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it.
- REQ-018: Any bounce (s2 != cand) before commit SHALL restart the count; sw_value SHALL not change for glitches shorter than DEBOUNCE_CYCLES clocks after synchronization.
- REQ-019: sw_changed SHALL be 1 for exactly the cycle after the edge on which sw_value changes value; rewriting an equal value SHALL not pulse.
- REQ-020: Button debounce SHALL use an independent candidate and counter with the rules of REQ-016/017, producing btn_level.
- REQ-021: btn_pulse SHALL be 1 for exactly one cycle after btn_level goes 0->1; no pulse on release.
- REQ-022: On btn_pulse, press_count SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000 without any flag.
- REQ-023: Event handshake states: IDLE (evt_valid=0), PENDING (evt_valid=1).
- REQ-024: IDLE -> PENDING on btn_pulse; PENDING -> IDLE on evt_ack with no btn_pulse.
- REQ-025: evt_ack and btn_pulse in the same cycle while PENDING SHALL leave evt_valid=1 and SHALL not set evt_overrun (old event consumed, new one pending).
- REQ-026: btn_pulse while PENDING without evt_ack SHALL set evt_overrun; evt_valid stays 1.
- REQ-027: evt_ack SHALL clear evt_overrun, unless the same cycle sets it per REQ-026, in which case evt_overrun=1 wins.
- REQ-028: evt_ack in IDLE SHALL have no effect.

Reset
- REQ-029: While reset=1 at an edge, all synchronizer flops, candidates, counters, sw_value, sw_changed, btn_level, btn_pulse, evt_valid, evt_overrun, press_count SHALL be 0.
- REQ-030: Reset mid-debounce SHALL discard the partial count; after release, inputs held at 1 SHALL be re-accepted after DEBOUNCE_CYCLES+3 edges, producing sw_changed and (for the button) btn_pulse as a fresh transition.

Verification (DEBOUNCE_CYCLES=4)
- REQ-031: Reset, then sw_in 16'h0000->16'hA5C3 held -> sw_value=16'hA5C3 and sw_changed=1 for one cycle exactly 7 edges later; no earlier change.
- REQ-032: btn_in pulses high 3 clocks, low 2, then high 10 -> single btn_pulse, press_count=1, evt_valid=1, evt_overrun=0.
- REQ-033: Two clean presses, no ack -> press_count=2, evt_valid=1, evt_overrun=1; evt_ack -> evt_valid=0, evt_overrun=0.
- REQ-034: evt_ack asserted in the same cycle as second btn_pulse -> evt_valid=1, evt_overrun=0.
- REQ-035: Preload via 65535 presses then one more -> press_count 16'hFFFF -> 16'h0000.
- REQ-036: reset asserted 2 cycles into sw_in=16'h0001 debounce, released with input held -> all outputs 0 during reset; sw_value=16'h0001 exactly 7 edges after release.
